// File: rtl/and_rr_scheduler_if.sv
// Request/response bundle between NCH requesters and the round-robin AND scheduler.
// The grant_cnt statistics bus exists only when AND_SCHED_STATS_EN is defined.
interface and_rr_scheduler_if #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int CNT_W = 8
);
    localparam int ID_W = $clog2(NCH);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("and_rr_scheduler_if: CNT_W must be >= 1");
    end

    logic [NCH-1:0]   req_valid;
    logic [NCH-1:0]   req_ready;
    logic [NCH*W-1:0] req_a;
    logic [NCH*W-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_y;
    logic [ID_W-1:0]  rsp_id;
    logic             busy;
`ifdef AND_SCHED_STATS_EN
    logic [NCH*CNT_W-1:0] grant_cnt;
`endif

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, busy
`ifdef AND_SCHED_STATS_EN
        , input grant_cnt
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, busy
`ifdef AND_SCHED_STATS_EN
        , output grant_cnt
`endif
    );
endinterface

// File: rtl/and_rr_scheduler.sv
// Round-robin front-end that time-shares one registered W-bit AND unit among NCH requesters.
// Define AND_SCHED_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module and_rr_scheduler #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and_rr_scheduler_if.slave    bus
);
    localparam int ID_W = $clog2(NCH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    if (NCH < 2) begin : g_bad_nch
        $error("and_rr_scheduler: NCH must be >= 2");
    end
    if (W < 1) begin : g_bad_w
        $error("and_rr_scheduler: W must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("and_rr_scheduler: CNT_W must be >= 1");
    end

    logic [0:0]      state_q;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [W-1:0]    rsp_y_q;

    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            can_issue;
    logic            issue;
    logic            rsp_fire;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Rotating priority: scan last+1, last+2, ... wrapping at NCH.
    always_comb begin
        logic [ID_W:0] cand;
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        grant_idx   = last_q;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = {1'b0, last_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NCH)) begin
                cand = cand - (ID_W+1)'(NCH);
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Gating with rst_n keeps every grant low while reset is held, not just after the first edge.
    assign can_issue = (state_q == IDLE) || bus.rsp_ready;
    assign issue     = rst_n && can_issue && grant_found;
    assign rsp_fire  = (state_q == RESP) && bus.rsp_ready;

    assign sel_a = bus.req_a[grant_idx*W +: W];
    assign sel_b = bus.req_b[grant_idx*W +: W];

    always_comb begin
        bus.req_ready = '0;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= ID_W'(NCH - 1);
            rsp_y_q  <= '0;
            rsp_id_q <= '0;
        end else if (issue) begin
            state_q  <= RESP;
            last_q   <= grant_idx;
            rsp_y_q  <= sel_a & sel_b;
            rsp_id_q <= grant_idx;
        end else if (rsp_fire) begin
            state_q  <= IDLE;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.busy      = (state_q == RESP);
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef AND_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (issue && (cnt_q[grant_idx] != '1)) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt_out
        assign bus.grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req_ready & ~bus.req_valid) == '0);

    a_stall_blocks_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |-> (bus.req_ready == '0));

    a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_y) && $stable(bus.rsp_id)));

endmodule

// File: tb/tb_and_rr_scheduler.sv
// Self-checking bench for and_rr_scheduler: directed scenarios plus a randomized run
// compared against a rotating-priority reference model.
module tb_and_rr_scheduler;
    localparam int NCH   = 4;
    localparam int W     = 4;
    localparam int CNT_W = 2;
    localparam int ID_W  = $clog2(NCH);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    and_rr_scheduler_if #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) bus ();

    and_rr_scheduler #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: pending flag, held result, last winner, grant counts.
    bit           m_pend;
    logic [W-1:0] m_y;
    int           m_id;
    int           m_last;
    int           m_cnt [NCH];

    task automatic model_reset();
        m_pend = 0;
        m_y    = '0;
        m_id   = 0;
        m_last = NCH - 1;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    // Winner = valid requester with the smallest rotational distance after the last winner.
    function automatic int model_pick(logic [NCH-1:0] v, int last);
        int best   = -1;
        int best_d = NCH;
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) begin
                int d;
                d = (i - last - 1 + 2 * NCH) % NCH;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        int g;
        g = model_pick(bus.req_valid, m_last);
        if ((!m_pend || bus.rsp_ready) && g >= 0) return NCH'(1) << g;
        return '0;
    endfunction

    task automatic model_edge();
        int g;
        g = model_pick(bus.req_valid, m_last);
        if ((!m_pend || bus.rsp_ready) && g >= 0) begin
            m_pend = 1;
            m_y    = bus.req_a[g*W +: W] & bus.req_b[g*W +: W];
            m_id   = g;
            m_last = g;
            if (m_cnt[g] < CMAX) m_cnt[g]++;
        end else if (m_pend && bus.rsp_ready) begin
            m_pend = 0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_a     = '1;
        bus.req_b     = '1;
        bus.rsp_ready = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (bus.req_ready !== '0) begin
            tests_failed++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready);
        end
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", bus.rsp_valid, bus.busy);
        end
        tests_run++;
        if (bus.rsp_y !== '0 || bus.rsp_id !== '0) begin
            tests_failed++; $display("FAIL reset_y_id: got %h/%0d expected 0/0", bus.rsp_y, bus.rsp_id);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
            tests_failed++; $display("FAIL reset_held_edge: got valid %b ready %b expected 0/0", bus.rsp_valid, bus.req_ready);
        end
`ifdef AND_SCHED_STATS_EN
        tests_run++;
        if (bus.grant_cnt !== '0) begin
            tests_failed++; $display("FAIL reset_grant_cnt: got %h expected 0", bus.grant_cnt);
        end
`endif
        @(negedge clk);
        bus.req_valid = '0;
        rst_n         = 1'b1;
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_a[0*W +: W] = W'(1);
        bus.req_b[0*W +: W] = W'(1);
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready);
        end
        advance();
        bus.req_valid = '0;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== W'(1) || bus.rsp_id !== ID_W'(0)) begin
            tests_failed++;
            $display("FAIL single_result: got valid %b y %h id %0d expected 1/1/0", bus.rsp_valid, bus.rsp_y, bus.rsp_id);
        end
        advance();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_drain: got valid %b busy %b expected 0/0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a [NCH];
        logic [W-1:0] b [NCH];
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
            bus.req_a[i*W +: W] = a[i];
            bus.req_b[i*W +: W] = b[i];
        end
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (bus.req_ready !== NCH'(1) << (k % NCH)) begin
                tests_failed++; $display("FAIL rr_grant[%0d]: got %b expected one-hot %0d", k, bus.req_ready, k % NCH);
            end
            advance();
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(k % NCH) ||
                bus.rsp_y !== (a[k % NCH] & b[k % NCH])) begin
                tests_failed++;
                $display("FAIL rr_result[%0d]: got valid %b id %0d y %h expected 1/%0d/%h",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_y, k % NCH, a[k % NCH] & b[k % NCH]);
            end
        end
        bus.req_valid = '0;
        advance();
    endtask

    task automatic test_stall();
        logic [W-1:0] y2;
        do_reset();
        bus.req_a[2*W +: W] = 4'b1101;
        bus.req_b[2*W +: W] = 4'b0111;
        y2 = 4'b0101;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL stall_first_grant: got %b expected 0100", bus.req_ready);
        end
        advance();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (bus.req_ready !== '0) begin
                tests_failed++; $display("FAIL stall_ready[%0d]: got %b expected 0000", k, bus.req_ready);
            end
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(2) || bus.rsp_y !== y2) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got valid %b id %0d y %h expected 1/2/%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_y, y2);
            end
            advance();
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL stall_release_grant: got %b expected 1000", bus.req_ready);
        end
        advance();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(3)) begin
            tests_failed++; $display("FAIL stall_release_id: got valid %b id %0d expected 1/3", bus.rsp_valid, bus.rsp_id);
        end
        bus.req_valid = '0;
        advance();
    endtask

    task automatic test_wide();
        do_reset();
        bus.req_a[1*W +: W] = 4'b1010;
        bus.req_b[1*W +: W] = 4'b0110;
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL wide_grant: got %b expected 0010", bus.req_ready);
        end
        advance();
        bus.req_valid = '0;
        tests_run++;
        if (bus.rsp_y !== 4'b0010 || bus.rsp_id !== ID_W'(1)) begin
            tests_failed++; $display("FAIL wide_result: got y %b id %0d expected 0010/1", bus.rsp_y, bus.rsp_id);
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        advance();
        advance();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(0)) begin
            tests_failed++; $display("FAIL areset_setup: got valid %b id %0d expected 1/0", bus.rsp_valid, bus.rsp_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== '0) begin
            tests_failed++;
            $display("FAIL areset_immediate: got valid %b busy %b ready %b expected 0/0/0", bus.rsp_valid, bus.busy, bus.req_ready);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL areset_restart: got %b expected 0001", bus.req_ready);
        end
        advance();
        bus.req_valid = '0;
        advance();
    endtask

`ifdef AND_SCHED_STATS_EN
    task automatic test_stats();
        int exp_seq [5] = '{1, 2, 3, 3, 3};
        do_reset();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            advance();
            tests_run++;
            if (bus.grant_cnt[0 +: CNT_W] !== CNT_W'(exp_seq[k]) || bus.grant_cnt[NCH*CNT_W-1:CNT_W] !== '0) begin
                tests_failed++;
                $display("FAIL stats_seq[%0d]: got %h expected cnt0=%0d others 0", k, bus.grant_cnt, exp_seq[k]);
            end
        end
        bus.req_valid = '0;
        advance();
    endtask
`endif

    task automatic test_random();
        logic [NCH-1:0] exp_ready;
        logic [NCH-1:0] prev_ready;
        int             waits [NCH];
        do_reset();
        prev_ready = '0;
        for (int i = 0; i < NCH; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!bus.req_valid[i] || prev_ready[i]) begin
                    bus.req_valid[i]    = ($urandom_range(0, 2) != 0);
                    bus.req_a[i*W +: W] = W'($urandom);
                    bus.req_b[i*W +: W] = W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = model_ready();
            tests_run++;
            if (bus.req_ready !== exp_ready) begin
                tests_failed++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.req_ready, exp_ready);
            end
            for (int i = 0; i < NCH; i++) begin
                if (!bus.req_valid[i] || exp_ready[i]) waits[i] = 0;
                else if (exp_ready != '0) waits[i]++;
            end
            tests_run++;
            for (int i = 0; i < NCH; i++) begin
                if (waits[i] >= NCH) begin
                    tests_failed++;
                    $display("FAIL rand_fairness[%0d]: requester %0d skipped %0d slots, limit %0d", c, i, waits[i], NCH - 1);
                    waits[i] = 0;
                    break;
                end
            end
            prev_ready = exp_ready;
            advance();
            tests_run++;
            if (bus.rsp_valid !== m_pend || bus.busy !== m_pend ||
                bus.rsp_y !== m_y || bus.rsp_id !== ID_W'(m_id)) begin
                tests_failed++;
                $display("FAIL rand_rsp[%0d]: got valid %b busy %b y %h id %0d expected %b/%b/%h/%0d",
                         c, bus.rsp_valid, bus.busy, bus.rsp_y, bus.rsp_id, m_pend, m_pend, m_y, m_id);
            end
`ifdef AND_SCHED_STATS_EN
            for (int i = 0; i < NCH; i++) begin
                tests_run++;
                if (bus.grant_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
                    tests_failed++;
                    $display("FAIL rand_cnt[%0d][%0d]: got %0d expected %0d", c, i, bus.grant_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
                end
            end
`endif
        end
        bus.req_valid = '0;
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wide();
        test_async_reset();
`ifdef AND_SCHED_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
